wb_commit_unit: RTL and testbench

Writeback commit unit for the RISC-V pipeline processor. It drives the register file's single write port (`WriteEn`/`WriteAddr`/`WriteData`). It merges single-cycle ALU results with variable-latency load results, which are buffered in a small FIFO. It also keeps a pending-destination scoreboard that the decode stage queries to stall on outstanding loads.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 62 ++++++
 rtl/wb_commit_unit.sv | 157 +++++++++++++++
 tb/tb_wb_commit_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit unit.
// Holds the default datapath widths, the default load-buffer depth and the
// buffered load-result entry type used by the load FIFO.
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int RA_W          = 5;
    localparam int WB_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering load results until the commit port is free.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (flushes pointers/count)
//   push, wdata    write request and entry; ignored when full
//   pop            read request; ignored when empty
//   rdata          head entry, valid whenever empty=0
//   count          occupancy 0..DEPTH
//   full, empty    occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int W     = $bits(wb_entry_t),
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage: data only, never reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: owns the register file's single write port.
// ALU results commit the cycle after they arrive and always take priority;
// load results are buffered in wb_fifo and drain when the ALU is idle.
// A pending-destination scoreboard lets decode stall on outstanding loads.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data      ALU result, always accepted
//   mem_valid/mem_ready/mem_rd/mem_data  load result handshake (ready registered)
//   iss_valid/iss_rd               load issued by decode, marks rd pending
//   src1_addr/src2_addr            decode source registers
//   src1_busy/src2_busy            source has an outstanding load
//   rf_we/rf_waddr/rf_wdata        registered register-file write port
module wb_commit_unit #(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int RA_W       = wb_pkg::RA_W,
    parameter int FIFO_DEPTH = wb_pkg::WB_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            alu_valid,
    input  logic [RA_W-1:0] alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [RA_W-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            iss_valid,
    input  logic [RA_W-1:0] iss_rd,
    input  logic [RA_W-1:0] src1_addr,
    input  logic [RA_W-1:0] src2_addr,
    output logic            src1_busy,
    output logic            src2_busy,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int NREG = 1 << RA_W;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          push_ent;
    entry_t          head_ent;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   next_count;
    logic            ready_q;

    logic            vld_p0;
    logic [RA_W-1:0] rd_p0;
    logic [XLEN-1:0] data_p0;
    logic            vld_p1;
    logic [RA_W-1:0] waddr_p1;
    logic [XLEN-1:0] wdata_p1;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    // Load acceptance and buffering
    assign push          = mem_valid && ready_q;
    assign pop           = !alu_valid && !fifo_empty;
    assign push_ent.rd   = mem_rd;
    assign push_ent.data = mem_data;

    wb_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head_ent),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        next_count = fifo_count;
        if (push && !pop)      next_count = fifo_count + 1'b1;
        else if (pop && !push) next_count = fifo_count - 1'b1;
    end

    // Ready only reflects a pop on the following cycle: no same-cycle bypass
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_q <= 1'b0;
        else       ready_q <= (next_count < DEPTH_C);
    end

    assign mem_ready = ready_q;

    // p0: commit arbitration, ALU first, else FIFO head
    always_comb begin
        vld_p0  = 1'b0;
        rd_p0   = alu_rd;
        data_p0 = alu_data;
        if (alu_valid) begin
            vld_p0 = 1'b1;
        end else if (!fifo_empty) begin
            vld_p0  = 1'b1;
            rd_p0   = head_ent.rd;
            data_p0 = head_ent.data;
        end
    end

    // p1: register-file write port; x0 commits are consumed but never written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0 && (rd_p0 != '0);
            if (vld_p0 && (rd_p0 != '0)) begin
                waddr_p1 <= rd_p0;
                wdata_p1 <= data_p0;
            end
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;

    // Scoreboard: clear on the edge the register file captures, set wins
    always_comb begin
        pend_nxt = pend;
        if (vld_p1) pend_nxt[waddr_p1] = 1'b0;
        if (iss_valid && (iss_rd != '0)) pend_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pend <= '0;
        else       pend <= pend_nxt;
    end

    assign src1_busy = (src1_addr != '0) && pend[src1_addr];
    assign src2_busy = (src2_addr != '0) && pend[src2_addr];

    // Decode must never send an ALU write to a register with a load in flight
    a_alu_not_pending: assert property (@(posedge clk) disable iff (!rstn)
        !(alu_valid && (alu_rd != '0) && pend[alu_rd]));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        !(push && fifo_full));

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic        src1_busy;
    logic        src2_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    wb_commit_unit #(.XLEN(32), .RA_W(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .src1_addr (src1_addr),
        .src2_addr (src2_addr),
        .src1_busy (src1_busy),
        .src2_busy (src2_busy),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
    } vec_t;

    ent_t        mq[$];
    exp_t        eq[$];
    logic [31:0] mpend;
    logic        mready;
    logic        prev_we;
    logic [4:0]  prev_addr;
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        eq.delete();
        mpend     = '0;
        mready    = 1'b0;
        prev_we   = 1'b0;
        prev_addr = '0;
    endtask

    // Drive one cycle of stimulus, predict the commit, then compare after the edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic iv, input logic [4:0] ir);
        ent_t e;
        exp_t x;
        logic acc;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md;
        iss_valid = iv; iss_rd = ir;
        acc = mv && mready;
        x = '0;
        if (av) begin
            x.we = (ar != 0); x.addr = ar; x.data = ad;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            x.we = (e.rd != 0); x.addr = e.rd; x.data = e.data;
        end
        if (acc) begin
            e.rd = mr; e.data = md;
            mq.push_back(e);
        end
        eq.push_back(x);
        if (prev_we) mpend[prev_addr] = 1'b0;
        if (iv && ir != 0) mpend[ir] = 1'b1;
        prev_we   = x.we;
        prev_addr = x.addr;
        mready    = (mq.size() < DEPTH);
        @(posedge clk);
        #1;
        x = eq.pop_front();
        chk("sb_rf_we", rf_we, x.we);
        if (x.we) begin
            chk("sb_rf_waddr", rf_waddr, x.addr);
            chk("sb_rf_wdata", rf_wdata, x.data);
        end
        chk("sb_mem_ready", mem_ready, mready);
        chk("sb_src1_busy", src1_busy, mpend[src1_addr] && src1_addr != 0);
        chk("sb_src2_busy", src2_busy, mpend[src2_addr] && src2_addr != 0);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_src1_busy", src1_busy, 1'b0);
        chk("rst_src2_busy", src2_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        src1_addr = 5'd9;
        src2_addr = 5'd10;
        tbl[0] = '{1'b1, 5'd7,  32'd25,         1'b1, 5'd7,  32'd25};
        tbl[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF,  1'b0, 5'd0,  32'd0};
        tbl[2] = '{1'b1, 5'd31, 32'hDEAD_BEEF,  1'b1, 5'd31, 32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 5'd3,  32'h1111_1111,  1'b0, 5'd0,  32'd0};
        tbl[4] = '{1'b1, 5'd1,  32'h0000_1234,  1'b1, 5'd1,  32'h0000_1234};
        tbl[5] = '{1'b1, 5'd15, 32'h8000_0000,  1'b1, 5'd15, 32'h8000_0000};

        apply_reset();

        // ALU-only vectors
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].av, tbl[i].ar, tbl[i].ad, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            chk("tbl_we", rf_we, tbl[i].ewe);
            if (tbl[i].ewe) begin
                chk("tbl_waddr", rf_waddr, tbl[i].ea);
                chk("tbl_wdata", rf_wdata, tbl[i].ed);
            end
        end

        // Load with scoreboard
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        chk("ld_busy_set", src1_busy, 1'b1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd4, 1'b0, 5'd0);
        chk("ld_no_early_we", rf_we, 1'b0);
        idle();
        chk("ld_we_n2", rf_we, 1'b1);
        chk("ld_waddr_n2", rf_waddr, 5'd9);
        chk("ld_wdata_n2", rf_wdata, 32'd4);
        chk("ld_busy_n2", src1_busy, 1'b1);
        idle();
        chk("ld_busy_n3", src1_busy, 1'b0);

        // Priority: buffered load waits behind three ALU results
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd6, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            chk("prio_alu_addr", rf_waddr, 5'd6);
        end
        idle();
        chk("prio_ld_we", rf_we, 1'b1);
        chk("prio_ld_addr", rf_waddr, 5'd5);
        chk("prio_ld_data", rf_wdata, 32'h5);

        // Full FIFO while the ALU owns the port
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(5 + i), 32'h50 + i, 1'b0, 5'd0);
        chk("full_ready_low", mem_ready, 1'b0);
        step(1'b1, 5'd1, 32'h200, 1'b1, 5'd12, 32'h99, 1'b0, 5'd0);
        chk("full_ready_hold", mem_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("full_pop_addr", rf_waddr, 5'(5 + i));
            chk("full_pop_data", rf_wdata, 32'h50 + i);
            if (i == 0) chk("full_ready_back", mem_ready, 1'b1);
        end

        // Back-to-back loads wrap the pointers
        for (int i = 0; i < 6; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'($urandom), 1'b0, 5'd0);
        idle();
        idle();

        // Set/clear collision on the same register
        step(1'b1, 5'd10, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("coll_we", rf_we, 1'b1);
        chk("coll_waddr", rf_waddr, 5'd10);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
        chk("coll_pend", src2_busy, 1'b1);
        idle();
        chk("coll_pend_hold", src2_busy, 1'b1);

        // Reset mid-operation with three buffered loads
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd9,  32'h99, 1'b1, 5'd9);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd10);
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hBB, 1'b0, 5'd0);
        chk("mid_busy1_pre", src1_busy, 1'b1);
        chk("mid_busy2_pre", src2_busy, 1'b1);
        apply_reset();
        idle();
        chk("post_ready", mem_ready, 1'b1);
        chk("post_busy1", src1_busy, 1'b0);
        chk("post_no_stale_we", rf_we, 1'b0);
        idle();
        chk("post_no_stale_we2", rf_we, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
